// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, ALU operation codes, control bundle
// and the opcode/immediate decode function used by decode_stage.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'b0000,
    OP_ANDI = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_LUI  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_ORI  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_LW   = 4'b1000,
    OP_SW   = 4'b1001,
    OP_BEQ  = 4'b1010,
    OP_JMP  = 4'b1011
  } opcode_e;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0100;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src1;
    logic       alu_src2;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_src;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] imm;
  } dec_t;

  // Immediate is built at 32 bits; callers truncate to their data width (<= 32).
  function automatic dec_t decode(input logic [3:0] op, input logic [8:0] lo,
                                  input int unsigned data_w);
    dec_t d;
    d = '0;
    d.ctrl.alu_op = ALU_ADD;
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI: begin
        d.imm = {{25{lo[6]}}, lo[6:0]};
        d.ctrl.alu_op = (op == OP_ADDI) ? ALU_ADD : (op == OP_ANDI) ? ALU_AND : ALU_OR;
        d.ctrl.alu_src2 = 1'b1;
        d.ctrl.reg_write = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d.ctrl.alu_op = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB :
                        (op == OP_AND) ? ALU_AND : ALU_OR;
        d.ctrl.reg_dst = 1'b1;
        d.ctrl.reg_write = 1'b1;
      end
      OP_LUI: begin
        d.imm = 32'(lo[5:0]) << (data_w - 32'd6);
        d.ctrl.alu_op = ALU_PASSB;
        d.ctrl.alu_src2 = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.illegal = ~|lo[5:0];
      end
      OP_LW, OP_SW: begin
        d.imm = 32'(lo[5:0]);
        d.ctrl.alu_src2 = 1'b1;
        d.ctrl.mem_to_reg = (op == OP_LW);
        d.ctrl.reg_write = (op == OP_LW);
        d.ctrl.mem_write = (op == OP_SW);
        d.ctrl.illegal = ~|lo[5:0];
      end
      OP_BEQ, OP_JMP: begin
        d.imm = {{23{lo[8]}}, lo[8:0]};
        d.ctrl.alu_op = (op == OP_BEQ) ? ALU_SUB : ALU_ADD;
        d.ctrl.alu_src1 = 1'b1;
        d.ctrl.reg_src = (op == OP_JMP);
      end
      default: d.ctrl.illegal = 1'b1;
    endcase
    if (d.ctrl.illegal) begin
      d.ctrl.reg_write = 1'b0;
      d.ctrl.mem_write = 1'b0;
      d.ctrl.mem_to_reg = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_skid_fifo.sv
// Two-entry FIFO holding packed decoded entries; flush empties it at the next edge.
module decode_skid_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, 2-entry skid buffer and
// RUN/TRAP illegal-instruction handling. Optional: DECODE_PERF_CNT_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               flush,
  input  logic               trap_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         opcode_out,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [DATA_W-1:0]  imm,
  output logic [3:0]         ALUOp,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrc1,
  output logic               ALUSrc2,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               RegSrc,
  output logic               illegal,
  output logic               trapped,
  output logic [31:0]        perf_count
);

  typedef enum logic {S_RUN, S_TRAP} state_e;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
  } entry_t;

  state_e     state_q, state_d;
  dec_t       dec;
  entry_t     in_e, head_e, out_e;
  logic [1:0] count;
  logic       accept, pop;

  always_comb begin
    dec         = decode(instr_i[INSTR_W-1 -: 4], instr_i[8:0], DATA_W);
    in_e.opcode = instr_i[INSTR_W-1 -: 4];
    in_e.rd     = instr_i[INSTR_W-5 -: REG_W];
    in_e.rs     = instr_i[INSTR_W-5-REG_W -: REG_W];
    in_e.imm    = DATA_W'(dec.imm);
    in_e.ctrl   = dec.ctrl;
  end

  assign in_ready  = (count < 2'd2) && (state_q == S_RUN);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept && in_e.ctrl.illegal) state_d = S_TRAP;
      S_TRAP:  if (trap_clear) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  decode_skid_fifo #(.W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head_e),
    .count (count)
  );

  // Payload is zeroed whenever nothing valid is presented.
  assign out_e      = out_valid ? head_e : '0;
  assign opcode_out = out_e.opcode;
  assign rd         = out_e.rd;
  assign rs         = out_e.rs;
  assign imm        = out_e.imm;
  assign ALUOp      = out_e.ctrl.alu_op;
  assign RegWrite   = out_e.ctrl.reg_write;
  assign RegDst     = out_e.ctrl.reg_dst;
  assign ALUSrc1    = out_e.ctrl.alu_src1;
  assign ALUSrc2    = out_e.ctrl.alu_src2;
  assign MemWrite   = out_e.ctrl.mem_write;
  assign MemToReg   = out_e.ctrl.mem_to_reg;
  assign RegSrc     = out_e.ctrl.reg_src;
  assign illegal    = out_e.ctrl.illegal;
  assign trapped    = (state_q == S_TRAP);

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (pop) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_count = perf_q;
`else
  assign perf_count = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, trap_clear, out_ready;
  logic [15:0] instr_i;
  logic        in_ready, out_valid;
  logic [3:0]  opcode_out, ALUOp;
  logic [2:0]  rd, rs;
  logic [15:0] imm;
  logic        RegWrite, RegDst, ALUSrc1, ALUSrc2, MemWrite, MemToReg, RegSrc, illegal, trapped;
  logic [31:0] perf_count;
  logic [37:0] obs_v;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [37:0] q[$];
  logic        m_trap;
  logic [31:0] m_perf;

  always #5 clk = ~clk;

  decode_stage #(.INSTR_W(16), .DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr_i(instr_i),
    .flush(flush), .trap_clear(trap_clear), .out_valid(out_valid), .out_ready(out_ready),
    .opcode_out(opcode_out), .rd(rd), .rs(rs), .imm(imm), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegSrc(RegSrc), .illegal(illegal),
    .trapped(trapped), .perf_count(perf_count)
  );

  assign obs_v = {opcode_out, rd, rs, imm, ALUOp, RegWrite, RegDst, ALUSrc1, ALUSrc2,
                  MemWrite, MemToReg, RegSrc, illegal};

  // Expected output vector, same layout as obs_v, derived from the opcode table.
  function automatic logic [37:0] ref_decode(input logic [15:0] ins);
    int op, low6, immv, alu;
    bit rw, rdst, as1, as2, mw, m2r, rsrc, ill;
    op = int'(ins[15:12]);
    low6 = int'(ins[5:0]);
    immv = 0; alu = 0;
    {rw, rdst, as1, as2, mw, m2r, rsrc, ill} = '0;
    case (op)
      0, 1, 5: begin
        immv = int'(ins[6:0]) - (ins[6] ? 128 : 0);
        alu = (op == 0) ? 0 : (op == 1) ? 2 : 3;
        as2 = 1; rw = 1;
      end
      2, 4, 6, 7: begin
        alu = (op == 2) ? 0 : (op == 4) ? 1 : (op == 6) ? 2 : 3;
        rdst = 1; rw = 1;
      end
      3: begin immv = low6 * 1024; alu = 4; as2 = 1; rw = 1; ill = (low6 == 0); end
      8: begin immv = low6; as2 = 1; m2r = 1; rw = 1; ill = (low6 == 0); end
      9: begin immv = low6; as2 = 1; mw = 1; ill = (low6 == 0); end
      10: begin immv = int'(ins[8:0]) - (ins[8] ? 512 : 0); alu = 1; as1 = 1; end
      11: begin immv = int'(ins[8:0]) - (ins[8] ? 512 : 0); as1 = 1; rsrc = 1; end
      default: ill = 1;
    endcase
    if (ill) begin rw = 0; mw = 0; m2r = 0; end
    return {ins[15:12], ins[11:9], ins[8:6], 16'(immv), 4'(alu),
            rw, rdst, as1, as2, mw, m2r, rsrc, ill};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare all outputs to the model before the edge, advance model.
  task automatic step(input logic iv, input logic [15:0] ins, input logic fl,
                      input logic tc, input logic ordy, input logic r);
    logic exp_rdy, acc, popm;
    logic [37:0] e;
    in_valid = iv; instr_i = ins; flush = fl; trap_clear = tc; out_ready = ordy; rst = r;
    @(negedge clk);
    exp_rdy = (q.size() < 2) && !m_trap;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("trapped", 64'(trapped), 64'(m_trap));
    chk("payload", 64'(obs_v), (q.size() != 0) ? 64'(q[0]) : 64'd0);
    chk("perf_count", 64'(perf_count), 64'(m_perf));
    @(posedge clk);
    e = ref_decode(ins);
    if (r) begin
      q.delete(); m_trap = 1'b0; m_perf = '0;
    end else begin
      popm = (q.size() != 0) && ordy;
      acc  = iv && exp_rdy && !fl;
`ifdef DECODE_PERF_CNT_EN
      if (popm) m_perf = m_perf + 32'd1;
`endif
      if (fl) q.delete();
      else begin
        if (popm) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (!m_trap && acc && e[0]) m_trap = 1'b1;
      else if (m_trap && tc) m_trap = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic ordy);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [15:0] s [4];
    rst = 1'b1; in_valid = 1'b0; instr_i = '0; flush = 1'b0; trap_clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_trap = 1'b0; m_perf = '0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_trapped", 64'(trapped), 64'd0);
    chk("reset_perf", 64'(perf_count), 64'd0);
    chk("reset_payload", 64'(obs_v), 64'd0);

    // ADDI imm7=10, one-cycle latency
    step(1'b1, 16'h020A, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'(imm), 64'h000A);
    chk("addi_ctrl", 64'({ALUSrc2, RegWrite, ALUOp}), 64'({1'b1, 1'b1, 4'b0000}));

    // BEQ offset -10
    step(1'b1, 16'hA1F6, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("beq_imm", 64'(imm), 64'hFFF6);
    chk("beq_ctrl", 64'({ALUOp, RegWrite}), 64'({4'b0001, 1'b0}));
    idle(2, 1'b1);

    // Backpressure: only two accepted, then drain in order
    s[0] = 16'h2A40; s[1] = 16'h4C80; s[2] = 16'h0E3F; s[3] = 16'h6250;
    for (int unsigned i = 0; i < 4; i++) step(1'b1, s[i], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(obs_v), 64'(ref_decode(s[0])));
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_second", 64'(obs_v), 64'(ref_decode(s[1])));
    idle(2, 1'b1);

    // Illegal opcode traps; trap_clear with in_valid does not accept
    step(1'b1, 16'hC123, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ill_flag", 64'({illegal, trapped, in_ready}), 64'({1'b1, 1'b1, 1'b0}));
    idle(2, 1'b1);
    step(1'b1, 16'h020A, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clear_in_ready", 64'(in_ready), 64'd1);
    chk("clear_no_accept", 64'(out_valid), 64'd0);

    // LW with zero offset is illegal, LW with offset 10 is legal
    step(1'b1, 16'h8240, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lw0_illegal", 64'({illegal, MemToReg, RegWrite}), 64'({1'b1, 1'b0, 1'b0}));
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h820A, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lw10", 64'({imm, MemToReg, illegal}), 64'({16'h000A, 1'b1, 1'b0}));
    idle(1, 1'b1);

    // Flush with two entries buffered, plus a same-cycle instruction
    step(1'b1, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hB1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_empty", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

    // Reset while trapped with entries buffered
    step(1'b1, 16'h1005, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid", 64'({out_valid, trapped, perf_count}), 64'd0);

    for (int unsigned i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, {4'($urandom_range(0, 15)), 12'($urandom)},
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), 1'b0);
    end
    idle(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
